oled_frame_sequencer: RTL and testbench
=======================================

// Module: oled_frame_sequencer
// PURPOSE
//  Sequences the SSD1331 OLED link: power-on reset pulse, init command stream, then full-frame
//  pixel pushes from the game framebuffer on request. Feeds the SPI byte shifter over a
//  valid/ready byte interface and owns oled_res_n and the D/C flag that travels with each byte.
// PARAMETERS
//  WIDTH         96    panel columns
//  HEIGHT        64    panel rows; NPIX = WIDTH*HEIGHT, RGB565, 2 bytes/pixel
//  RESET_CYCLES  1000  clk cycles res_n held low, then again high before init
//  INIT_LEN      24    command bytes in init ROM
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   synchronous, active-low reset
//  frame_req   in   1   1-cycle pulse: redraw full frame
//  busy        out  1   1 whenever state != IDLE
//  init_done   out  1   sticky high once init stream fully accepted
//  frame_done  out  1   1-cycle pulse after last pixel byte accepted
//  fb_rd_en    out  1   framebuffer read strobe
//  fb_addr     out  $clog2(NPIX)  pixel index, row-major
//  fb_data     in   16  RGB565, valid cycle after fb_rd_en
//  tx_valid    out  1   byte offered to SPI shifter
//  tx_ready    in   1   shifter accepts byte this cycle
//  tx_byte     out  8   byte to shift
//  tx_dc       out  1   0 = command, 1 = data; sampled with tx_byte
//  oled_res_n  out  1   panel hardware reset, active low
// BEHAVIOUR
//  Reset values: oled_res_n=0, tx_valid=0, tx_byte=0, tx_dc=0, fb_rd_en=0, fb_addr=0,
//   init_done=0, frame_done=0, busy=1, pending=0, state=RST_LO. Reset mid-operation aborts
//   everything incl. an offered byte (tx_valid=0 next cycle) and restarts the full sequence.
//  Handshake: transfer iff tx_valid&&tx_ready. While tx_valid=1 and !tx_ready, tx_byte/tx_dc
//   held stable. tx_valid may be re-asserted the cycle after a transfer (back-to-back).
//  FSM:
//   RST_LO : res_n=0, count RESET_CYCLES -> RST_HI (counter cleared)
//   RST_HI : res_n=1, count RESET_CYCLES -> INIT
//   INIT   : dc=0, bytes init_rom[0..INIT_LEN-1]; after last accept init_done=1 ->
//            WINDOW if pending else IDLE
//   IDLE   : busy=0; frame_req -> WINDOW next cycle, tx_valid=1 same next cycle
//   WINDOW : dc=0, 6 bytes: 0x15,0x00,WIDTH-1,0x75,0x00,HEIGHT-1; after last -> FETCH, addr=0
//   FETCH  : fb_rd_en=1 one cycle at fb_addr -> LATCH
//   LATCH  : register fb_data into pix -> PIX_HI
//   PIX_HI : dc=1, byte pix[15:8]; accept -> PIX_LO
//   PIX_LO : dc=1, byte pix[7:0]; accept: addr==NPIX-1 -> DONE, else addr+1 -> FETCH
//   DONE   : frame_done=1 one cycle; addr=0; -> WINDOW if pending (pending cleared) else IDLE
//  pending: set by frame_req in any state except IDLE; multiple requests collapse to one;
//   frame_req coincident with DONE is serviced by the immediately following frame.
//  fb_addr wraps only via explicit clear in DONE; never exceeds NPIX-1.
//  Counters sized $clog2(max+1); no arithmetic overflow permitted at parameter defaults.
// STRUCTURE
//  oled_pkg: state enum (RST_LO..DONE), SSD1331 opcodes CMD_SET_COL=0x15, CMD_SET_ROW=0x75,
//   DC_CMD/DC_DATA constants.
//  Sub-module oled_init_rom: combinational index -> byte lookup (INIT_LEN entries:
//   display off, remap 0x72, start line, offset, normal mode, mux, master cfg, contrast,
//   display on). Sequencer holds byte index and FSM only.
// TESTING (bench params WIDTH=2, HEIGHT=2, RESET_CYCLES=4; shifter model with tx_ready control)
//  1 Release rst_n -> oled_res_n low exactly 4 cycles, high 4 cycles, then first INIT byte
//    equals rom[0] with tx_dc=0; busy=1 throughout.
//  2 tx_ready=1 always -> INIT_LEN cmd bytes in ROM order, init_done rises after last, busy=0.
//  3 frame_req in IDLE, fb = {0x1234,0xABCD,0x0F0F,0xF0F0} -> bytes 15 00 01 75 00 01 (dc=0)
//    then 12 34 AB CD 0F 0F F0 F0 (dc=1), frame_done single pulse, busy=0 after.
//  4 tx_ready toggled randomly 25% -> tx_byte/tx_dc never change while valid&&!ready;
//    byte stream identical to scenario 3.
//  5 Three frame_req pulses during frame and one during INIT -> exactly one extra frame each
//    time; total frames = requests serviced, no dropped/duplicate frame.
//  6 rst_n low during PIX_LO stall -> tx_valid=0 next cycle, res_n=0, init_done=0,
//    full reset/init sequence repeats before any pixel byte.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1331 OLED link: sequencer states, panel opcodes,
// D/C flag encodings and the fixed lengths of the command streams.
package oled_pkg;

    typedef enum logic [3:0] {
        RST_LO,
        RST_HI,
        INIT,
        IDLE,
        WINDOW,
        FETCH,
        LATCH,
        PIX_HI,
        PIX_LO,
        DONE
    } oled_state_e;

    localparam logic [7:0] CMD_SET_COL = 8'h15;
    localparam logic [7:0] CMD_SET_ROW = 8'h75;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int WIN_LEN   = 6;
    localparam int ROM_DEPTH = 24;

endpackage

// File: rtl/oled_init_rom.sv
// Power-up command stream for the SSD1331: off, remap, geometry, drive settings, on.
// Pure lookup; indices past the table read as 0x00.
module oled_init_rom
    import oled_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       data
);

    localparam logic [7:0] ROM [ROM_DEPTH] = '{
        8'hAE,                  // display off
        8'hA0, 8'h72,           // remap: RGB565, COM split
        8'hA1, 8'h00,           // start line
        8'hA2, 8'h00,           // display offset
        8'hA4,                  // normal display mode
        8'hA8, 8'h3F,           // multiplex 1/64
        8'hAD, 8'h8E,           // master config, external Vcc
        8'h81, 8'h91,           // contrast A
        8'h82, 8'h50,           // contrast B
        8'h83, 8'h7D,           // contrast C
        8'h87, 8'h06,           // master current
        8'hB1, 8'h31,           // phase period
        8'h2E,                  // scrolling off
        8'hAF                   // display on
    };

    always_comb begin
        data = 8'h00;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            if (idx == IDX_W'(i)) begin
                data = ROM[i];
            end
        end
    end

endmodule

// File: rtl/oled_frame_sequencer.sv
// SSD1331 link sequencer: panel reset pulse, init command stream, then full-frame
// pixel pushes from the framebuffer over a valid/ready byte interface.
module oled_frame_sequencer
    import oled_pkg::*;
#(
    parameter int WIDTH        = 96,
    parameter int HEIGHT       = 64,
    parameter int RESET_CYCLES = 1000,
    parameter int INIT_LEN     = 24
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_req,
    output logic                              busy,
    output logic                              init_done,
    output logic                              frame_done,
    output logic                              fb_rd_en,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   fb_addr,
    input  logic [15:0]                       fb_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic [7:0]                        tx_byte,
    output logic                              tx_dc,
    output logic                              oled_res_n
);

    localparam int NPIX    = WIDTH * HEIGHT;
    localparam int ADDR_W  = $clog2(NPIX);
    localparam int CNT_W   = $clog2(RESET_CYCLES + 1);
    localparam int IDX_MAX = (INIT_LEN > WIN_LEN) ? INIT_LEN : WIN_LEN;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);

    localparam logic [7:0] COL_END = 8'(WIDTH - 1);
    localparam logic [7:0] ROW_END = 8'(HEIGHT - 1);

    function automatic logic [7:0] win_byte(input logic [IDX_W-1:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            IDX_W'(0): b = CMD_SET_COL;
            IDX_W'(1): b = 8'h00;
            IDX_W'(2): b = COL_END;
            IDX_W'(3): b = CMD_SET_ROW;
            IDX_W'(4): b = 8'h00;
            IDX_W'(5): b = ROW_END;
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

    oled_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        pix_lo_q, pix_lo_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_dc_q, tx_dc_d;
    logic              fb_rd_en_q, fb_rd_en_d;
    logic              init_done_q, init_done_d;
    logic              frame_done_q, frame_done_d;
    logic              pending_q, pending_d;
    logic              oled_res_n_q, oled_res_n_d;

    logic              accept;
    logic [IDX_W-1:0]  rom_idx;
    logic [7:0]        rom_byte;

    // While streaming init, the ROM looks one entry ahead so the next byte is ready on accept.
    assign rom_idx = (state_q == INIT) ? idx_q + IDX_W'(1) : '0;

    oled_init_rom #(
        .IDX_W (IDX_W)
    ) u_init_rom (
        .idx  (rom_idx),
        .data (rom_byte)
    );

    assign accept = tx_valid_q && tx_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        fb_addr_d    = fb_addr_q;
        pix_lo_d     = pix_lo_q;
        tx_byte_d    = tx_byte_q;
        tx_valid_d   = tx_valid_q;
        tx_dc_d      = tx_dc_q;
        fb_rd_en_d   = 1'b0;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        oled_res_n_d = oled_res_n_q;
        pending_d    = pending_q | (frame_req && (state_q != IDLE));

        case (state_q)
            RST_LO: begin
                oled_res_n_d = 1'b0;
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    cnt_d        = '0;
                    oled_res_n_d = 1'b1;
                    state_d      = RST_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RST_HI: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    cnt_d      = '0;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = rom_byte;
                    tx_dc_d    = DC_CMD;
                    state_d    = INIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            INIT: begin
                if (accept) begin
                    if (idx_q == IDX_W'(INIT_LEN - 1)) begin
                        init_done_d = 1'b1;
                        // A request that arrived during init goes straight into a frame.
                        if (pending_d) begin
                            pending_d  = 1'b0;
                            idx_d      = '0;
                            tx_byte_d  = CMD_SET_COL;
                            tx_dc_d    = DC_CMD;
                            state_d    = WINDOW;
                        end else begin
                            tx_valid_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        tx_byte_d = rom_byte;
                    end
                end
            end
            IDLE: begin
                if (frame_req) begin
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = CMD_SET_COL;
                    tx_dc_d    = DC_CMD;
                    state_d    = WINDOW;
                end
            end
            WINDOW: begin
                if (accept) begin
                    if (idx_q == IDX_W'(WIN_LEN - 1)) begin
                        tx_valid_d = 1'b0;
                        fb_addr_d  = '0;
                        fb_rd_en_d = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        tx_byte_d = win_byte(idx_q + IDX_W'(1));
                    end
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                pix_lo_d   = fb_data[7:0];
                tx_valid_d = 1'b1;
                tx_byte_d  = fb_data[15:8];
                tx_dc_d    = DC_DATA;
                state_d    = PIX_HI;
            end
            PIX_HI: begin
                if (accept) begin
                    tx_byte_d = pix_lo_q;
                    state_d   = PIX_LO;
                end
            end
            PIX_LO: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    if (fb_addr_q == ADDR_W'(NPIX - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        fb_addr_d  = fb_addr_q + ADDR_W'(1);
                        fb_rd_en_d = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            DONE: begin
                fb_addr_d = '0;
                // A request coincident with DONE is folded into pending_d and served now.
                if (pending_d) begin
                    pending_d  = 1'b0;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = CMD_SET_COL;
                    tx_dc_d    = DC_CMD;
                    state_d    = WINDOW;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = RST_LO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RST_LO;
            cnt_q        <= '0;
            idx_q        <= '0;
            fb_addr_q    <= '0;
            pix_lo_q     <= '0;
            tx_byte_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_dc_q      <= DC_CMD;
            fb_rd_en_q   <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            oled_res_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            fb_addr_q    <= fb_addr_d;
            pix_lo_q     <= pix_lo_d;
            tx_byte_q    <= tx_byte_d;
            tx_valid_q   <= tx_valid_d;
            tx_dc_q      <= tx_dc_d;
            fb_rd_en_q   <= fb_rd_en_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            oled_res_n_q <= oled_res_n_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
    assign fb_rd_en   = fb_rd_en_q;
    assign fb_addr    = fb_addr_q;
    assign tx_valid   = tx_valid_q;
    assign tx_byte    = tx_byte_q;
    assign tx_dc      = tx_dc_q;
    assign oled_res_n = oled_res_n_q;

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Directed bench for oled_frame_sequencer on a 2x2 panel with a short reset pulse,
// a registered framebuffer model and a byte sink with controllable ready.
module tb_oled_frame_sequencer;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int RC = 4;

    localparam logic [7:0] ROM_EXP [24] = '{
        8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
        8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'h81, 8'h91, 8'h82, 8'h50,
        8'h83, 8'h7D, 8'h87, 8'h06, 8'hB1, 8'h31, 8'h2E, 8'hAF
    };

    // {dc, byte} for one frame of fb = {1234, ABCD, 0F0F, F0F0}
    localparam logic [8:0] FRAME_EXP [14] = '{
        9'h015, 9'h000, 9'h001, 9'h075, 9'h000, 9'h001,
        9'h112, 9'h134, 9'h1AB, 9'h1CD, 9'h10F, 9'h10F, 9'h1F0, 9'h1F0
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_req = 1'b0;
    logic        tx_ready = 1'b0;
    logic        busy, init_done, frame_done, fb_rd_en;
    logic [1:0]  fb_addr;
    logic [15:0] fb_data = 16'h0000;
    logic        tx_valid, tx_dc, oled_res_n;
    logic [7:0]  tx_byte;

    logic [15:0] fb_mem [4] = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0};

    oled_frame_sequencer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .RESET_CYCLES (RC),
        .INIT_LEN     (24)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_req  (frame_req),
        .busy       (busy),
        .init_done  (init_done),
        .frame_done (frame_done),
        .fb_rd_en   (fb_rd_en),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_byte    (tx_byte),
        .tx_dc      (tx_dc),
        .oled_res_n (oled_res_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fb_rd_en) fb_data <= fb_mem[fb_addr];
    end

    // 0: always ready, 1: ready 75% of cycles, 2: never ready
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 3) != 0);
            default: tx_ready = 1'b0;
        endcase
    end

    logic [8:0] got_q [$];
    int         frames = 0;
    int         fd_long = 0;
    int         stab_err = 0;
    logic       fd_prev = 1'b0;
    logic       stall_prev = 1'b0;
    logic [8:0] stall_val = 9'h000;

    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) got_q.push_back({tx_dc, tx_byte});
        if (rst_n && frame_done) begin
            frames <= frames + 1;
            if (fd_prev) fd_long <= fd_long + 1;
        end
        fd_prev <= frame_done;
        if (rst_n && stall_prev && (!tx_valid || ({tx_dc, tx_byte} != stall_val)))
            stab_err <= stab_err + 1;
        stall_prev <= rst_n && tx_valid && !tx_ready;
        stall_val  <= {tx_dc, tx_byte};
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag, input int base);
        check_eq({tag, "_len"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                check_eq($sformatf("%s[%0d]", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
        end
    endtask

    task automatic add_rom();
        for (int i = 0; i < 24; i++) exp_q.push_back({1'b0, ROM_EXP[i]});
    endtask

    task automatic add_frame();
        for (int i = 0; i < 14; i++) exp_q.push_back(FRAME_EXP[i]);
    endtask

    task automatic pulse_req();
        @(posedge clk); #1 frame_req = 1'b1;
        @(posedge clk); #1 frame_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < max) begin
            n++;
            @(negedge clk);
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    // Called right after rst_n rises; ends on the first cycle offering an init byte.
    task automatic check_por(input string tag);
        int nlo, nhi;
        logic busy_ok;
        nlo = 0;
        nhi = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!oled_res_n && nlo < 50) begin
            busy_ok = busy_ok & busy;
            nlo++;
            @(negedge clk);
        end
        while (oled_res_n && !tx_valid && nhi < 50) begin
            busy_ok = busy_ok & busy;
            nhi++;
            @(negedge clk);
        end
        check_eq({tag, "_res_lo"}, 32'(nlo), 32'(RC));
        check_eq({tag, "_res_hi"}, 32'(nhi), 32'(RC));
        check_eq({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check_eq({tag, "_valid0"}, 32'(tx_valid), 32'd1);
        check_eq({tag, "_byte0"}, 32'(tx_byte), 32'h0000_00AE);
        check_eq({tag, "_dc0"}, 32'(tx_dc), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, fbase, sbase, n;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_res_n", 32'(oled_res_n), 32'd0);
        check_eq("rst_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_byte", 32'(tx_byte), 32'd0);
        check_eq("rst_dc", 32'(tx_dc), 32'd0);
        check_eq("rst_rd_en", 32'(fb_rd_en), 32'd0);
        check_eq("rst_addr", 32'(fb_addr), 32'd0);
        check_eq("rst_init_done", 32'(init_done), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);

        // Reset pulse timing and init stream with ready held high
        base = got_q.size();
        @(posedge clk); #1 rst_n = 1'b1;
        check_por("por1");
        n = 0;
        while (!init_done && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq("init_done", 32'(init_done), 32'd1);
        check_eq("init_busy", 32'(busy), 32'd0);
        exp_q = {};
        add_rom();
        check_stream("init", base);

        // Single frame, always ready
        base  = got_q.size();
        fbase = frames;
        pulse_req();
        wait_idle("f1_idle", 200);
        exp_q = {};
        add_frame();
        check_stream("f1", base);
        check_eq("f1_frames", 32'(frames - fbase), 32'd1);
        check_eq("f1_fd_pulse", 32'(fd_long), 32'd0);

        // Same frame with random back-pressure
        rdy_mode = 1;
        base  = got_q.size();
        fbase = frames;
        sbase = stab_err;
        pulse_req();
        wait_idle("f2_idle", 600);
        rdy_mode = 0;
        check_stream("f2", base);
        check_eq("f2_frames", 32'(frames - fbase), 32'd1);
        check_eq("f2_stable", 32'(stab_err - sbase), 32'd0);

        // Three requests during a frame collapse into exactly one extra frame
        base  = got_q.size();
        fbase = frames;
        pulse_req();
        pulse_req();
        repeat (2) @(posedge clk);
        pulse_req();
        n = 0;
        @(negedge clk);
        while (!(tx_valid && tx_dc) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq("f3_saw_pix", 32'(tx_valid && tx_dc), 32'd1);
        pulse_req();
        wait_idle("f3_idle", 400);
        exp_q = {};
        add_frame();
        add_frame();
        check_stream("f3", base);
        check_eq("f3_frames", 32'(frames - fbase), 32'd2);
        check_eq("f3_fd_pulse", 32'(fd_long), 32'd0);

        // Reset while stalled on the low pixel byte
        pulse_req();
        n = 0;
        @(negedge clk);
        while (!(tx_valid && tx_dc) && n < 100) begin
            n++;
            @(negedge clk);
        end
        rdy_mode = 2;
        @(negedge clk);
        check_eq("stall_valid", 32'(tx_valid), 32'd1);
        check_eq("stall_dc", 32'(tx_dc), 32'd1);
        check_eq("stall_byte", 32'(tx_byte), 32'h34);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_valid", 32'(tx_valid), 32'd0);
        check_eq("abort_res_n", 32'(oled_res_n), 32'd0);
        check_eq("abort_init_done", 32'(init_done), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd1);
        rdy_mode = 0;
        @(posedge clk); #1;
        base  = got_q.size();
        fbase = frames;
        @(posedge clk); #1 rst_n = 1'b1;
        check_por("por2");

        // Request during init is served right after the last init byte
        pulse_req();
        wait_idle("f4_idle", 400);
        exp_q = {};
        add_rom();
        add_frame();
        check_stream("f4", base);
        check_eq("f4_frames", 32'(frames - fbase), 32'd1);
        check_eq("f4_init_done", 32'(init_done), 32'd1);
        check_eq("f4_fd_pulse", 32'(fd_long), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
